inst_decoder: RTL and testbench
===============================

# inst_decoder

Registered instruction-decode stage of the LITE-16 core. Accepts 16-bit instruction words from fetch over a valid/ready handshake and splits them into fields. Produces the ALU control (codeop, ri, compare condition), register addresses, extended immediate and write-enable for execute through a one-entry output register. Tracks in-flight register writes and stalls read-after-write hazards until writeback retires them.

## Interface
- No parameters; all widths are fixed by the LITE-16 ISA (16-bit word, 8 registers).
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch presents in_instr
- in_instr  in  16  instruction word
- in_ready  out  1  decoder accepts in_instr this cycle
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes bundle this cycle
- out_class  out  2  00 ALU-R, 01 ALU-I, 10 branch, 11 mem/system
- out_codeop  out  3  ALU codeop; for branches `{1'b0,cond}`
- out_ri  out  1  1 selects ALU immediate path (mv/mvu)
- out_rd, out_rs1, out_rs2  out  3 each  register addresses
- out_imm  out  16  extended immediate
- out_we  out  1  instruction writes out_rd
- out_load, out_store, out_illegal  out  1 each  memory op / undefined encoding
- flush  in  1  squash output register and halt state (taken branch)
- wb_valid  in  1  writeback retires a write
- wb_rd  in  3  register retired
- halted  out  1  halt instruction accepted

## Operation
Encoding:
- [15:14] class.
- R: [13:11] codeop, [10:8] rd, [7:5] rs1, [4:2] rs2, [1:0] must be 00.
  - we=1, ri=0, imm=0.
- I: [13] u, [12:11] must be 00, [10:8] rd, [7:0] imm8.
  - codeop=`{2'b00,~u}`: mv=001, mvu=000; ri=1, we=1.
  - rs1=rd (mv reads old rd); imm=`{8'h00,imm8}`.
- Branch: [13:12] cond, [11:9] rs1, [8:6] rs2, [5:0] off6.
  - imm = sign-extended off6; we=0; cond 11 = unconditional.
- Mem/sys: [13:11] sub.
  - 000 ld: rd=[10:8], rs1=[7:5], imm=sext [4:0], we=1, load=1.
  - 001 st: rs2=[10:8] data, rs1=[7:5] base, imm=sext [4:0], we=0, store=1.
  - 111 halt.
  - Others illegal.
- Any nonzero must-be-zero field sets illegal.
- Illegal encodings decode as a NOP bundle: we=0, load=0, store=0, illegal=1.

Handshake and hazards:
- in_ready = !halted && !hazard && (!out_valid || out_ready).
- hazard = in_valid && a source actually used by the instruction (rs1/rs2 per class) is pending in the scoreboard, or equals out_rd of a valid out_we bundle.
- Scoreboard sets bit out_rd on an output handshake with out_we=1. It clears bit wb_rd on wb_valid.
  - Same register set and cleared in one cycle: set wins.
- Halt: accepting halt sets halted; the halt bundle is still emitted (class 11, we=0). halted is sticky until reset or flush.
- flush: out_valid<=0 next edge. The squashed bundle never sets the scoreboard; halted<=0. An input handshake in the flush cycle is discarded.

## Timing
- Reset: all out_* 0, out_valid 0, halted 0, scoreboard all clear; in_ready 1 after reset.
- Latency 1: input accepted at edge N produces out_valid from N.
- Throughput 1/cycle with no hazards.
- out_valid high with out_ready low: bundle held stable, in_ready 0.
- wb_valid clearing a hazard at edge N: in_ready rises combinationally in cycle N+1.
- rst_n asserted mid-operation: immediate clear; in-flight bundle lost.

## Configuration
- DECODE_SCOREBOARD_EN defined: scoreboard and hazard stall as above.
- Not defined: scoreboard removed and hazard tied 0 (software schedules). wb_valid/wb_rd remain as ports, ignored.

## Structure
- lite16_pkg holds:
  - class constants CLS_R/CLS_I/CLS_BR/CLS_MEM
  - codeop constants OP_ADD..OP_CAT
  - condition codes CMP_EQ/LT/GT/ALW
  - mem sub-op codes
  - decoded-bundle struct typedef
- Sub-module reg_scoreboard: 8-bit pending vector, set/clear ports, two read ports.

## Test plan
- Reset, then R `0b00_010_011_001_010_00` -> next cycle out_codeop=010, rd=3, rs1=1, rs2=2, we=1, ri=0.
- I mvu rd=4 imm8=0xA5 -> codeop=000, ri=1, imm=0x00A5, we=1; then mv rd=4 -> codeop=001, rs1=4.
- Branch cond=01 off6=0x3E -> imm=0xFFFE, we=0, codeop=001.
- Scoreboard:
  - Issue `add r3` with out_ready=1, then instruction reading r3 -> in_ready 0.
  - wb_valid, wb_rd=3 -> accepted next cycle.
- out_ready held low 3 cycles -> bundle stable, in_ready 0.
- Flush while holding a bundle -> out_valid 0, no scoreboard bit set.
- Halt -> halted=1, in_ready 0 until flush.
- Encoding 11_010 -> illegal=1, we=0.

Source files
------------

// File: rtl/lite16_pkg.sv
// LITE-16 shared decode constants and the decoded-bundle type.
// Used by inst_decoder and reg_scoreboard.
package lite16_pkg;

    localparam int unsigned NREGS = 8;

    localparam logic [1:0] CLS_R   = 2'b00;
    localparam logic [1:0] CLS_I   = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_MEM = 2'b11;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_CAT = 3'd7;

    localparam logic [1:0] CMP_EQ  = 2'b00;
    localparam logic [1:0] CMP_LT  = 2'b01;
    localparam logic [1:0] CMP_GT  = 2'b10;
    localparam logic [1:0] CMP_ALW = 2'b11;

    localparam logic [2:0] MEM_LD   = 3'b000;
    localparam logic [2:0] MEM_ST   = 3'b001;
    localparam logic [2:0] MEM_HALT = 3'b111;

    typedef struct packed {
        logic [1:0]  cls;
        logic [2:0]  codeop;
        logic        ri;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic [15:0] imm;
        logic        we;
        logic        load;
        logic        store;
        logic        illegal;
    } dec_t;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

endpackage

// File: rtl/inst_decoder_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue,
// cleared on writeback; a same-cycle set beats the clear.
module reg_scoreboard
    import lite16_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_i,
    input  logic [2:0] set_rd_i,
    input  logic       clr_i,
    input  logic [2:0] clr_rd_i,
    input  logic [2:0] rd1_addr_i,
    input  logic [2:0] rd2_addr_i,
    output logic       rd1_o,
    output logic       rd2_o
);

    logic [NREGS-1:0] pend_q, pend_d;

    // Next pending vector: clear first so a set of the same bit wins
    always_comb begin
        pend_d = pend_q;
        if (clr_i) pend_d[clr_rd_i] = 1'b0;
        if (set_i) pend_d[set_rd_i] = 1'b1;
    end

    // Pending vector register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign rd1_o = pend_q[rd1_addr_i];
    assign rd2_o = pend_q[rd2_addr_i];

endmodule

// File: rtl/inst_decoder.sv
// LITE-16 registered decode stage with RAW hazard stall.
// Macro DECODE_SCOREBOARD_EN enables the scoreboard/hazard logic.
module inst_decoder
    import lite16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_class,
    output logic [2:0]  out_codeop,
    output logic        out_ri,
    output logic [2:0]  out_rd,
    output logic [2:0]  out_rs1,
    output logic [2:0]  out_rs2,
    output logic [15:0] out_imm,
    output logic        out_we,
    output logic        out_load,
    output logic        out_store,
    output logic        out_illegal,
    input  logic        flush,
    input  logic        wb_valid,
    input  logic [2:0]  wb_rd,
    output logic        halted
);

    dec_t dec_d, dec_q;
    logic out_valid_q, halted_q;
    logic use_rs1, use_rs2, is_halt, bad;
    logic hazard, in_fire;

    // Split the instruction word into the decoded bundle
    always_comb begin
        dec_d     = '0;
        dec_d.cls = in_instr[15:14];
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        is_halt   = 1'b0;
        bad       = 1'b0;
        unique case (in_instr[15:14])
            CLS_R: begin
                dec_d.codeop = in_instr[13:11];
                dec_d.rd     = in_instr[10:8];
                dec_d.rs1    = in_instr[7:5];
                dec_d.rs2    = in_instr[4:2];
                dec_d.we     = 1'b1;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
                bad          = |in_instr[1:0];
            end
            CLS_I: begin
                dec_d.codeop = {2'b00, ~in_instr[13]};
                dec_d.ri     = 1'b1;
                dec_d.rd     = in_instr[10:8];
                dec_d.rs1    = in_instr[10:8];
                dec_d.imm    = {8'h00, in_instr[7:0]};
                dec_d.we     = 1'b1;
                use_rs1      = 1'b1;
                bad          = |in_instr[12:11];
            end
            CLS_BR: begin
                dec_d.codeop = {1'b0, in_instr[13:12]};
                dec_d.rs1    = in_instr[11:9];
                dec_d.rs2    = in_instr[8:6];
                dec_d.imm    = sext6(in_instr[5:0]);
                use_rs1      = in_instr[13:12] != CMP_ALW;
                use_rs2      = in_instr[13:12] != CMP_ALW;
            end
            CLS_MEM: begin
                dec_d.codeop = OP_ADD;
                case (in_instr[13:11])
                    MEM_LD: begin
                        dec_d.rd   = in_instr[10:8];
                        dec_d.rs1  = in_instr[7:5];
                        dec_d.imm  = sext5(in_instr[4:0]);
                        dec_d.we   = 1'b1;
                        dec_d.load = 1'b1;
                        use_rs1    = 1'b1;
                    end
                    MEM_ST: begin
                        dec_d.rs2   = in_instr[10:8];
                        dec_d.rs1   = in_instr[7:5];
                        dec_d.imm   = sext5(in_instr[4:0]);
                        dec_d.store = 1'b1;
                        use_rs1     = 1'b1;
                        use_rs2     = 1'b1;
                    end
                    MEM_HALT: is_halt = 1'b1;
                    default:  bad = 1'b1;
                endcase
            end
        endcase
        if (bad) begin
            dec_d         = '0;
            dec_d.cls     = in_instr[15:14];
            dec_d.illegal = 1'b1;
            use_rs1       = 1'b0;
            use_rs2       = 1'b0;
        end
    end

`ifdef DECODE_SCOREBOARD_EN
    logic sb_set, pend1, pend2, fwd1, fwd2;

    assign sb_set = out_valid_q && out_ready && dec_q.we && !flush;

    reg_scoreboard u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_i      (sb_set),
        .set_rd_i   (dec_q.rd),
        .clr_i      (wb_valid),
        .clr_rd_i   (wb_rd),
        .rd1_addr_i (dec_d.rs1),
        .rd2_addr_i (dec_d.rs2),
        .rd1_o      (pend1),
        .rd2_o      (pend2)
    );

    // The bundle sitting in the output register is not yet in the
    // scoreboard, so compare against it directly
    assign fwd1   = out_valid_q && dec_q.we && (dec_q.rd == dec_d.rs1);
    assign fwd2   = out_valid_q && dec_q.we && (dec_q.rd == dec_d.rs2);
    assign hazard = in_valid && ((use_rs1 && (pend1 || fwd1))
                              || (use_rs2 && (pend2 || fwd2)));
`else
    logic unused_cfg;
    assign unused_cfg = ^{wb_valid, wb_rd, use_rs1, use_rs2};
    assign hazard     = 1'b0;
`endif

    assign in_ready = !halted_q && !hazard && (!out_valid_q || out_ready);
    assign in_fire  = in_valid && in_ready;

    // One-entry output register, halt latch and flush squash
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q       <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else if (in_fire) begin
            dec_q       <= dec_d;
            out_valid_q <= 1'b1;
            if (is_halt) halted_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid   = out_valid_q;
    assign halted      = halted_q;
    assign out_class   = dec_q.cls;
    assign out_codeop  = dec_q.codeop;
    assign out_ri      = dec_q.ri;
    assign out_rd      = dec_q.rd;
    assign out_rs1     = dec_q.rs1;
    assign out_rs2     = dec_q.rs2;
    assign out_imm     = dec_q.imm;
    assign out_we      = dec_q.we;
    assign out_load    = dec_q.load;
    assign out_store   = dec_q.store;
    assign out_illegal = dec_q.illegal;

endmodule

// File: tb/tb_inst_decoder.sv
// Bench for inst_decoder: directed cases plus randomized traffic
// checked by a queue-based reference model.
module tb_inst_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_instr = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_class;
    logic [2:0]  out_codeop;
    logic        out_ri;
    logic [2:0]  out_rd, out_rs1, out_rs2;
    logic [15:0] out_imm;
    logic        out_we, out_load, out_store, out_illegal;
    logic        flush = 1'b0;
    logic        wb_valid = 1'b0;
    logic [2:0]  wb_rd = '0;
    logic        halted;

    inst_decoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_codeop(out_codeop), .out_ri(out_ri),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .out_we(out_we), .out_load(out_load),
        .out_store(out_store), .out_illegal(out_illegal),
        .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  cls;
        logic [2:0]  op;
        logic        ri;
        logic [2:0]  rd, rs1, rs2;
        logic [15:0] imm;
        logic        we, ld, st, ill;
        logic        halt, u1, u2;
    } mdl_t;

    mdl_t       q[$];
    logic [7:0] pend;
    logic       m_halt;
    bit         done;
    int         n_vec, n_err;

    logic [34:0] dut_b;
    assign dut_b = {out_class, out_codeop, out_ri, out_rd, out_rs1,
                    out_rs2, out_imm, out_we, out_load, out_store,
                    out_illegal};

    function automatic logic [34:0] pack(input mdl_t m);
        return {m.cls, m.op, m.ri, m.rd, m.rs1, m.rs2, m.imm,
                m.we, m.ld, m.st, m.ill};
    endfunction

    // Reference decode computed from the field layout with arithmetic
    function automatic mdl_t model(input logic [15:0] w);
        mdl_t m;
        int   v, cls, a, b, off, cond;
        bit   bad;
        m    = '0;
        bad  = 0;
        v    = int'(w);
        cls  = v / 16384;
        a    = (v / 2048) % 8;
        b    = (v / 256) % 8;
        m.cls = 2'(cls);
        if (cls == 0) begin
            m.op  = 3'(a);
            m.rd  = 3'(b);
            m.rs1 = 3'((v / 32) % 8);
            m.rs2 = 3'((v / 4) % 8);
            m.we  = 1;
            m.u1  = 1;
            m.u2  = 1;
            bad   = (v % 4) != 0;
        end else if (cls == 1) begin
            m.op  = ((v / 8192) % 2 == 1) ? 3'd0 : 3'd1;
            m.ri  = 1;
            m.rd  = 3'(b);
            m.rs1 = 3'(b);
            m.imm = 16'(v % 256);
            m.we  = 1;
            m.u1  = 1;
            bad   = ((v / 2048) % 4) != 0;
        end else if (cls == 2) begin
            cond  = (v / 4096) % 4;
            m.op  = 3'(cond);
            m.rs1 = 3'((v / 512) % 8);
            m.rs2 = 3'((v / 64) % 8);
            off   = v % 64;
            if (off >= 32) off -= 64;
            m.imm = 16'(off);
            m.u1  = cond != 3;
            m.u2  = cond != 3;
        end else begin
            off = v % 32;
            if (off >= 16) off -= 32;
            if (a == 0) begin
                m.rd  = 3'(b);
                m.rs1 = 3'((v / 32) % 8);
                m.imm = 16'(off);
                m.we  = 1;
                m.ld  = 1;
                m.u1  = 1;
            end else if (a == 1) begin
                m.rs2 = 3'(b);
                m.rs1 = 3'((v / 32) % 8);
                m.imm = 16'(off);
                m.st  = 1;
                m.u1  = 1;
                m.u2  = 1;
            end else if (a == 7) begin
                m.halt = 1;
            end else begin
                bad = 1;
            end
        end
        if (bad) begin
            m       = '0;
            m.cls   = 2'(cls);
            m.ill   = 1;
        end
        return m;
    endfunction

    task automatic chk(input string nm, input logic [34:0] act,
                       input logic [34:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit busy(input logic [2:0] r);
        bit h;
        h = 0;
`ifdef DECODE_SCOREBOARD_EN
        h = pend[r] || (q.size() != 0 && q[0].we && q[0].rd == r);
`endif
        return h;
    endfunction

    // Scoreboard monitor: compare at the falling edge, then apply the
    // effects of the coming rising edge to the model
    task automatic monitor();
        mdl_t   nx;
        bit     hz, er, set;
        logic [2:0] srd;
        while (!done) begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                pend   = '0;
                m_halt = 0;
            end else begin
                nx = model(in_instr);
                hz = in_valid && ((nx.u1 && busy(nx.rs1))
                               || (nx.u2 && busy(nx.rs2)));
                er = !m_halt && !hz && (q.size() == 0 || out_ready);
                chk("in_ready", 35'(in_ready), 35'(er));
                chk("out_valid", 35'(out_valid), 35'(q.size() != 0));
                chk("halted", 35'(halted), 35'(m_halt));
                if (q.size() != 0 && out_valid)
                    chk("bundle", dut_b, pack(q[0]));
                set = 0;
                srd = '0;
                if (flush) begin
                    q.delete();
                    m_halt = 0;
                end else begin
                    if (q.size() != 0 && out_ready) begin
                        set = q[0].we;
                        srd = q[0].rd;
                        void'(q.pop_front());
                    end
                    if (in_valid && er) begin
                        q.push_back(nx);
                        if (nx.halt) m_halt = 1;
                    end
                end
                if (wb_valid && !(set && srd == wb_rd)) pend[wb_rd] = 0;
                if (set) pend[srd] = 1;
            end
        end
    endtask

    task automatic cyc(input bit iv, input logic [15:0] w, input bit ordy,
                       input bit fl, input bit wbv, input logic [2:0] wbr);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_instr  = w;
        out_ready = ordy;
        flush     = fl;
        wb_valid  = wbv;
        wb_rd     = wbr;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic retire_all();
        for (int r = 0; r < 8; r++) cyc(0, '0, 1, 0, 1, 3'(r));
        cyc(0, '0, 1, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_valid  = 0;
        out_ready = 0;
        flush     = 0;
        wb_valid  = 0;
        rst_n     = 0;
        settle();
        chk("rst_out_valid", 35'(out_valid), 35'(0));
        chk("rst_bundle", dut_b, 35'(0));
        @(posedge clk);
        #1;
        rst_n = 1;
        settle();
        chk("rst_in_ready", 35'(in_ready), 35'(1));
        chk("rst_halted", 35'(halted), 35'(0));
    endtask

    task automatic driver();
        logic [15:0] w;
        do_reset();

        cyc(1, 16'h1328, 1, 0, 0, 0);
        cyc(0, '0, 1, 0, 0, 0);
        settle();
        chk("r_codeop", 35'(out_codeop), 35'(3'b010));
        chk("r_regs", 35'({out_rd, out_rs1, out_rs2}), 35'({3'd3, 3'd1, 3'd2}));
        chk("r_we_ri", 35'({out_we, out_ri}), 35'(2'b10));
        retire_all();

        cyc(1, 16'h64A5, 1, 0, 0, 0);
        cyc(0, '0, 1, 0, 0, 0);
        settle();
        chk("mvu", 35'({out_codeop, out_ri, out_imm, out_we}),
            35'({3'b000, 1'b1, 16'h00A5, 1'b1}));
        retire_all();
        cyc(1, 16'h4412, 1, 0, 0, 0);
        cyc(0, '0, 1, 0, 0, 0);
        settle();
        chk("mv", 35'({out_codeop, out_rs1, out_imm}),
            35'({3'b001, 3'd4, 16'h0012}));
        retire_all();

        cyc(1, 16'h903E, 1, 0, 0, 0);
        cyc(0, '0, 1, 0, 0, 0);
        settle();
        chk("branch", 35'({out_imm, out_we, out_codeop}),
            35'({16'hFFFE, 1'b0, 3'b001}));

`ifdef DECODE_SCOREBOARD_EN
        retire_all();
        cyc(1, 16'h0300, 1, 0, 0, 0);
        cyc(1, 16'h016C, 1, 0, 0, 0);
        settle();
        chk("raw_fwd_stall", 35'(in_ready), 35'(0));
        cyc(1, 16'h016C, 1, 0, 1, 3);
        settle();
        chk("raw_pend_stall", 35'(in_ready), 35'(0));
        cyc(1, 16'h016C, 1, 0, 0, 0);
        settle();
        chk("raw_release", 35'(in_ready), 35'(1));
        cyc(0, '0, 1, 0, 0, 0);
        settle();
        chk("raw_issued", 35'({out_rd, out_rs1}), 35'({3'd1, 3'd3}));
`endif
        retire_all();

        cyc(1, 16'h1328, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1, 16'hB000, 0, 0, 0, 0);
            settle();
            chk("hold_bundle", 35'({out_valid, out_rd, out_codeop, in_ready}),
                35'({1'b1, 3'd3, 3'b010, 1'b0}));
        end
        cyc(0, '0, 1, 0, 0, 0);
        retire_all();

        cyc(1, 16'h0500, 0, 0, 0, 0);
        cyc(0, '0, 0, 1, 0, 0);
        cyc(0, '0, 1, 0, 0, 0);
        settle();
        chk("flush_squash", 35'(out_valid), 35'(0));
`ifdef DECODE_SCOREBOARD_EN
        cyc(1, 16'h00A0, 1, 0, 0, 0);
        settle();
        chk("flush_no_set", 35'(in_ready), 35'(1));
`endif
        retire_all();

        cyc(1, 16'hF800, 1, 0, 0, 0);
        cyc(1, 16'h1328, 1, 0, 0, 0);
        settle();
        chk("halt_bundle", 35'({halted, in_ready, out_class, out_we}),
            35'({1'b1, 1'b0, 2'b11, 1'b0}));
        cyc(1, 16'h1328, 1, 0, 0, 0);
        cyc(1, 16'h1328, 1, 0, 0, 0);
        settle();
        chk("halt_sticky", 35'({halted, in_ready}), 35'(2'b10));
        cyc(0, '0, 1, 1, 0, 0);
        cyc(0, '0, 1, 0, 0, 0);
        settle();
        chk("halt_flush", 35'({halted, in_ready}), 35'(2'b01));

        cyc(1, 16'hD000, 1, 0, 0, 0);
        cyc(1, 16'h1329, 1, 0, 0, 0);
        settle();
        chk("illegal_mem", 35'({out_illegal, out_we, out_load, out_store}),
            35'(4'b1000));
        cyc(0, '0, 1, 0, 0, 0);
        settle();
        chk("illegal_r", 35'({out_illegal, out_we}), 35'(2'b10));
        retire_all();

        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            w = 16'($urandom);
            if (w[15:11] == 5'b11111 && ($urandom % 4) != 0)
                w[13:11] = 3'b000;
            cyc(($urandom % 4) != 0, w, ($urandom % 4) != 0,
                ($urandom % 20) == 0, ($urandom % 3) == 0,
                3'($urandom % 8));
        end
        cyc(0, '0, 1, 0, 0, 0);
        settle();
        done = 1;
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        done   = 0;
        pend   = '0;
        m_halt = 0;
        fork
            driver();
            monitor();
        join
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
